// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//
// Contents:
//   GROUP_W  - width of one lookahead group (4 bits).
//   cfg_ok() - true when a WIDTH/STAGES pair splits into equal segments
//              made only of whole lookahead groups.
//
// The stage register record depends on WIDTH, which a package cannot
// see. It is therefore declared inside pipelined_cla_adder.
package pipe_adder_pkg;

  localparam int GROUP_W = 4;

  function automatic bit cfg_ok(input int width, input int stages);
    return (width > 0) && (stages > 0) &&
           (width % stages == 0) &&
           ((width / stages) % GROUP_W == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group.
//
// Ports:
//   a_i, b_i [3:0] - operand bits of this group
//   cin_i          - carry into bit 0 of the group
//   sum_o   [3:0]  - sum bits
//   cout_o         - carry out of bit 3
//
// All group carries are in full lookahead form, with no ripple inside
// the group. Groups are chained by the caller.
module cla_group4
  import pipe_adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] sum_o,
  output logic               cout_o
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_o  = p ^ c[GROUP_W-1:0];
  assign cout_o = c[GROUP_W];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The operands are split into STAGES segments of SEG = WIDTH/STAGES bits.
// Each pipeline stage resolves one segment. Inside a segment the work is
// a ripple of 4-bit lookahead groups. The segment carry is registered
// between stages.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - input handshake for operands a, b, cin, sub
//   a, b [WIDTH-1:0]    - operands
//   cin                 - carry-in (ignored when sub=1)
//   sub                 - 1: a-b, 0: a+b+cin
//   out_valid/out_ready - output handshake for sum, carry
//   sum [WIDTH-1:0]     - result modulo 2^WIDTH
//   carry               - carry out of the MSB (for sub: 1 = no borrow)
//   overflow            - signed overflow; present only when
//                         PIPE_ADDER_OVERFLOW_EN is defined
//
// Optional feature macro: PIPE_ADDER_OVERFLOW_EN.
//
// Handshake: a beat moves across an interface on a rising edge only when
// valid and ready are both high in the cycle before that edge. valid
// never depends on ready. A held beat keeps its payload stable until it
// transfers.
module pipelined_cla_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPE_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / GROUP_W;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH/STAGES must be a whole multiple of 4");
  end

  // One pipeline register.
  //   sum_lo - holds the resolved low bits. Bits above the resolved range are 0.
  //   a_hi, b_hi - hold the operand bits not yet added. Resolved bits are cleared.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
`ifdef PIPE_ADDER_OVERFLOW_EN
    logic             ovf;
`endif
  } stage_t;

  stage_t            st_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // Subtraction is a + ~b + 1. The sub flag is resolved here, so it is
  // not carried down the pipe.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  // A stage may load when it is empty or when its content moves on.
  // This lets bubbles collapse even while the output is stalled.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = out_ready || !st_q[STAGES-1].valid;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !st_q[k].valid || adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    // Keeps only the operand bits above this stage's segment.
    localparam logic [WIDTH-1:0] HI_MASK =
      ~({WIDTH{1'b1}} >> (WIDTH - (k + 1) * SEG));

    logic             src_v;
    logic             src_c;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [NG:0]      gc;
    logic [SEG-1:0]   seg_sum;
    stage_t           nxt;
    stage_t           q;

    if (k == 0) begin : g_src_in
      assign src_v = in_valid;
      assign src_c = c_eff;
      assign src_s = '0;
      assign src_a = a;
      assign src_b = b_eff;
    end else begin : g_src_pipe
      assign src_v = st_q[k-1].valid;
      assign src_c = st_q[k-1].carry;
      assign src_s = st_q[k-1].sum_lo;
      assign src_a = st_q[k-1].a_hi;
      assign src_b = st_q[k-1].b_hi;
    end

    // Carries ripple from group to group inside the segment.
    assign gc[0] = src_c;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group4 u_grp (
        .a_i   (src_a[LO + g*GROUP_W +: GROUP_W]),
        .b_i   (src_b[LO + g*GROUP_W +: GROUP_W]),
        .cin_i (gc[g]),
        .sum_o (seg_sum[g*GROUP_W +: GROUP_W]),
        .cout_o(gc[g+1])
      );
    end

    always_comb begin
      nxt                  = '0;
      nxt.valid            = 1'b1;
      nxt.sum_lo           = src_s;
      nxt.sum_lo[LO +: SEG] = seg_sum;
      nxt.carry            = gc[NG];
      nxt.a_hi             = src_a & HI_MASK;
      nxt.b_hi             = src_b & HI_MASK;
`ifdef PIPE_ADDER_OVERFLOW_EN
      // Carry into the segment MSB is recovered as a ^ b ^ sum at that bit.
      // Only the last stage's value (the word MSB) reaches the output.
      nxt.ovf = src_a[LO+SEG-1] ^ src_b[LO+SEG-1] ^ seg_sum[SEG-1] ^ gc[NG];
`endif
    end

    // The payload loads only with a real beat. This keeps sum quiet
    // while bubbles pass through the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (adv[k]) begin
        if (src_v) q <= nxt;
        else       q.valid <= 1'b0;
      end
    end

    assign st_q[k] = q;
  end

  assign in_ready  = adv[0];
  assign out_valid = st_q[STAGES-1].valid;
  assign sum       = st_q[STAGES-1].sum_lo;
  assign carry     = st_q[STAGES-1].carry;
`ifdef PIPE_ADDER_OVERFLOW_EN
  assign overflow  = st_q[STAGES-1].ovf;
`endif

endmodule
